not_alu: RTL and testbench



---
 rtl/not_alu_pkg.sv | 13 +
 rtl/not_alu_flag_gen.sv | 30 +++
 rtl/not_alu.sv | 82 ++++++++
 tb/tb_not_alu.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/not_alu_pkg.sv
// not_alu shared package: slice width and the ALU status flag bundle.
// Optional parity output is enabled with NOT_ALU_PARITY_EN.
package not_alu_pkg;

    localparam int NOT_ALU_WIDTH = 32;

    typedef struct packed {
        logic of;
        logic cary;
        logic eq;
    } not_alu_flags_t;

endpackage

// File: rtl/not_alu_flag_gen.sv
// not_alu flag generator: status flags derived from the complemented value.
// Parity output present only when NOT_ALU_PARITY_EN is defined.
module not_alu_flag_gen
    import not_alu_pkg::*;
#(
    parameter int WIDTH = NOT_ALU_WIDTH
) (
    input  logic [WIDTH-1:0] i_s,
`ifdef NOT_ALU_PARITY_EN
    output logic             o_par,
`endif
    output not_alu_flags_t   o_flags
);

    // NOT has no carry-out or signed overflow; eq flags an all-zero result
    always_comb begin
        o_flags      = '0;
        o_flags.of   = 1'b0;
        o_flags.cary = 1'b0;
        o_flags.eq   = (i_s == '0);
    end

`ifdef NOT_ALU_PARITY_EN
    // Even/odd parity of the result word
    always_comb begin
        o_par = ^i_s;
    end
`endif

endmodule

// File: rtl/not_alu.sv
// not_alu: registered bitwise-complement ALU slice with status flags.
// Define NOT_ALU_PARITY_EN to add the registered parity output par.
module not_alu
    import not_alu_pkg::*;
#(
    parameter int WIDTH = NOT_ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             of,
    output logic             cary,
`ifdef NOT_ALU_PARITY_EN
    output logic             par,
`endif
    output logic             eq
);

    logic [WIDTH-1:0] w_s;
    not_alu_flags_t   w_flags;
    logic [WIDTH-1:0] r_s;
    not_alu_flags_t   r_flags;
    logic             r_valid;

    // Invert the operand; no sign or width extension
    always_comb begin
        w_s = ~a;
    end

`ifdef NOT_ALU_PARITY_EN
    logic w_par;
    logic r_par;
`endif

    not_alu_flag_gen #(
        .WIDTH   (WIDTH)
    ) u_flag_gen (
        .i_s     (w_s),
`ifdef NOT_ALU_PARITY_EN
        .o_par   (w_par),
`endif
        .o_flags (w_flags)
    );

    // Result registers: capture on in_valid, hold otherwise; reset wins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_s     <= '0;
            r_flags <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_s     <= w_s;
                r_flags <= w_flags;
            end
        end
    end

`ifdef NOT_ALU_PARITY_EN
    // Parity register follows the same capture/hold rule as the result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (in_valid) begin
            r_par <= w_par;
        end
    end

    assign par = r_par;
`endif

    assign out_valid = r_valid;
    assign s         = r_s;
    assign of        = r_flags.of;
    assign cary      = r_flags.cary;
    assign eq        = r_flags.eq;

endmodule

// File: tb/tb_not_alu.sv
// tb_not_alu: directed self-checking bench for the not_alu slice.
// Parity checks are included when NOT_ALU_PARITY_EN is defined.
module tb_not_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic        out_valid;
    logic [31:0] s;
    logic        of;
    logic        cary;
    logic        eq;
`ifdef NOT_ALU_PARITY_EN
    logic        par;
`endif

    int n_cmp;
    int n_err;

    not_alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .out_valid (out_valid),
        .s         (s),
        .of        (of),
        .cary      (cary),
`ifdef NOT_ALU_PARITY_EN
        .par       (par),
`endif
        .eq        (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, then sample outputs 1ns after the next rising edge
    task automatic step(input logic rn, input logic v, input logic [31:0] av);
        rst_n    = rn;
        in_valid = v;
        a        = av;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 32'h1234_5678);
        step(1'b0, 1'b1, 32'h1234_5678);
        n_cmp++;
        if (s !== 32'h0) begin
            n_err++;
            $display("FAIL reset_s: got %h want %h", s, 32'h0);
        end
        n_cmp++;
        if (of !== 1'b0) begin
            n_err++;
            $display("FAIL reset_of: got %b want 0", of);
        end
        n_cmp++;
        if (cary !== 1'b0) begin
            n_err++;
            $display("FAIL reset_cary: got %b want 0", cary);
        end
        n_cmp++;
        if (eq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_eq: got %b want 0", eq);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b want 0", out_valid);
        end
`ifdef NOT_ALU_PARITY_EN
        n_cmp++;
        if (par !== 1'b0) begin
            n_err++;
            $display("FAIL reset_par: got %b want 0", par);
        end
`endif
    endtask

    task automatic test_zero();
        step(1'b1, 1'b1, 32'h0000_0000);
        n_cmp++;
        if (s !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL zero_s: got %h want %h", s, 32'hFFFF_FFFF);
        end
        n_cmp++;
        if (eq !== 1'b0) begin
            n_err++;
            $display("FAIL zero_eq: got %b want 0", eq);
        end
        n_cmp++;
        if (of !== 1'b0 || cary !== 1'b0) begin
            n_err++;
            $display("FAIL zero_ofc: got of=%b cary=%b want 0/0", of, cary);
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL zero_valid: got %b want 1", out_valid);
        end
`ifdef NOT_ALU_PARITY_EN
        n_cmp++;
        if (par !== 1'b0) begin
            n_err++;
            $display("FAIL zero_par: got %b want 0", par);
        end
`endif
    endtask

    task automatic test_ones();
        step(1'b1, 1'b1, 32'hFFFF_FFFF);
        n_cmp++;
        if (s !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL ones_s: got %h want %h", s, 32'h0);
        end
        n_cmp++;
        if (eq !== 1'b1) begin
            n_err++;
            $display("FAIL ones_eq: got %b want 1", eq);
        end
        n_cmp++;
        if (of !== 1'b0 || cary !== 1'b0) begin
            n_err++;
            $display("FAIL ones_ofc: got of=%b cary=%b want 0/0", of, cary);
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL ones_valid: got %b want 1", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b1, 32'hFFFF_0000);
        n_cmp++;
        if (s !== 32'h0000_FFFF || eq !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_hi: got s=%h eq=%b v=%b want 0000ffff/0/1",
                     s, eq, out_valid);
        end
        step(1'b1, 1'b1, 32'h0000_FFFF);
        n_cmp++;
        if (s !== 32'hFFFF_0000 || eq !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_lo: got s=%h eq=%b v=%b want ffff0000/0/1",
                     s, eq, out_valid);
        end
    endtask

    task automatic test_hold();
        step(1'b1, 1'b1, 32'hAAAA_AAAA);
        n_cmp++;
        if (s !== 32'h5555_5555 || eq !== 1'b0) begin
            n_err++;
            $display("FAIL alt_s: got s=%h eq=%b want 55555555/0", s, eq);
        end
        step(1'b1, 1'b0, 32'hFFFF_FFFF);
        n_cmp++;
        if (s !== 32'h5555_5555) begin
            n_err++;
            $display("FAIL hold_s: got %h want %h", s, 32'h5555_5555);
        end
        n_cmp++;
        if (eq !== 1'b0) begin
            n_err++;
            $display("FAIL hold_eq: got %b want 0", eq);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL hold_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 32'hFFFF_FFFF);
        n_cmp++;
        if (eq !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre_eq: got %b want 1", eq);
        end
        step(1'b0, 1'b1, 32'hFFFF_FFFF);
        n_cmp++;
        if (eq !== 1'b0 || s !== 32'h0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_rst: got eq=%b s=%h v=%b want 0/0/0",
                     eq, s, out_valid);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        test_reset();
        test_zero();
        test_ones();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
